// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared CPU definitions used by the instruction fetch stage.
//   * address-region boundaries of the 12-bit AGC K address space
//   * fixed-fixed bank numbers and the INHINT bubble encoding
//   * fetch FSM state enum and the FIFO entry struct
//   * map_fetch_addr(): K address + bits_FB -> physical ROM word address
package fetch_pkg;

    localparam logic [11:0] REGION_FB_BASE  = 12'o2000;  // start of fixed-switchable window
    localparam logic [11:0] REGION_FF2_BASE = 12'o4000;  // start of fixed-fixed bank 2
    localparam logic [11:0] REGION_FF3_BASE = 12'o6000;  // start of fixed-fixed bank 3

    localparam logic [2:0]  FF_BANK_2 = 3'd2;
    localparam logic [2:0]  FF_BANK_3 = 3'd3;

    // INHINT; decode treats it as a NOOP, so it doubles as the pipeline bubble.
    localparam logic [14:0] INHINT_INSTR = 15'o00004;

    localparam int PHYS_AW = 13;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [14:0] instr;
        logic [11:0] pc;
    } fetch_entry_t;

    function automatic logic is_erasable(input logic [11:0] fa);
        return fa < REGION_FB_BASE;
    endfunction

    // Erasable addresses never reach the ROM; their mapping is a don't-care.
    function automatic logic [PHYS_AW-1:0] map_fetch_addr(input logic [11:0] fa,
                                                          input logic [2:0]  fb);
        if (fa >= REGION_FF3_BASE)
            return {FF_BANK_3, fa[9:0]};
        else if (fa >= REGION_FF2_BASE)
            return {FF_BANK_2, fa[9:0]};
        else
            return {fb, fa[9:0]};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- 2-entry instr+pc buffer absorbing decode back-pressure.
// Entry 0 is always the head, so the head is a plain register read.
// Ports:
//   clock, rst   : clock, synchronous active-high reset (empties the FIFO)
//   i_clear      : discard all entries (branch redirect)
//   i_push       : write i_data (must not be asserted when full)
//   i_pop        : drop the head (must not be asserted when empty)
//   o_head       : current head entry
//   o_count      : number of valid entries, 0..2
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_push,
    input  logic         i_pop,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic [1:0]   r_count;

    always_ff @(posedge clock) begin
        if (rst || i_clear) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_mem[0] <= i_data;
                    else                 r_mem[1] <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem[0] <= r_mem[1];
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous pop and push: count is unchanged.
                    if (r_count == 2'd1) begin
                        r_mem[0] <= i_data;
                    end else begin
                        r_mem[0] <= r_mem[1];
                        r_mem[1] <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem[0];
    assign o_count = r_count;

endmodule

// File: rtl/fetch.sv
// fetch -- AGC instruction fetch stage feeding decode.
// Maps the K address onto the banked ROM, issues one synchronous read per
// cycle, buffers returns in a 2-entry FIFO and handles branch redirects.
// Ports:
//   clock, rst         : clock, synchronous active-high reset
//   stall              : decode cannot accept; output register holds
//   halt               : level; suppresses new ROM reads
//   redirect/_pc       : branch taken later in the pipe, with target K address
//   bits_FB            : fixed-bank register, sampled when the read issues
//   imem_rd_en/_addr   : ROM read strobe and physical word address
//   imem_rdata         : ROM data, valid the cycle after imem_rd_en
//   instr/pc/instr_valid : output register to decode
//   fetch_err          : sticky, an erasable fetch was attempted
//   bubble_cnt         : only with FETCH_BUBBLE_CNT_EN, saturating count of
//                        cycles with instr_valid=0 and stall=0
module fetch
    import fetch_pkg::*;
#(
    parameter int          ROM_AW       = 13,
    parameter logic [11:0] RESET_PC     = 12'o4000,
    parameter logic [14:0] BUBBLE_INSTR = INHINT_INSTR
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              redirect,
    input  logic [11:0]       redirect_pc,
    input  logic [2:0]        bits_FB,
    output logic              imem_rd_en,
    output logic [ROM_AW-1:0] imem_addr,
    input  logic [14:0]       imem_rdata,
    output logic [14:0]       instr,
    output logic [11:0]       pc,
    output logic              instr_valid,
    output logic              fetch_err
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    output logic [15:0]       bubble_cnt
`endif
);

    fetch_state_e r_state, w_state_nxt;

    logic [11:0]  r_fetch_pc;
    logic         r_inflight;
    logic         r_infl_epoch;
    logic [11:0]  r_infl_pc;
    logic         r_epoch;

    logic [14:0]  r_instr;
    logic [11:0]  r_pc;
    logic         r_valid;

    logic [11:0]  w_fa;
    logic         w_erasable;
    logic         w_room;
    logic         w_err_block;
    logic         w_attempt;
    logic         w_issue;
    logic         w_ret_ok;
    logic         w_fifo_empty;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_fifo_cnt;
    fetch_entry_t w_fifo_head;
    fetch_entry_t w_ret_entry;
    logic [PHYS_AW-1:0] w_phys;

    // ---------------- issue side ----------------
    assign w_fa       = redirect ? redirect_pc : r_fetch_pc;
    assign w_erasable = is_erasable(w_fa);
    assign w_phys     = map_fetch_addr(w_fa, bits_FB);

    // A redirect flushes FIFO and in-flight read this cycle, so the target
    // always has room even if the buffer is currently full.
    assign w_room = redirect ||
                    (({1'b0, w_fifo_cnt} + {2'b00, r_inflight}) <= 3'd1);

    // A redirect to a valid target lifts the error block in the same cycle.
    assign w_err_block = (r_state == ST_ERR) && !(redirect && !w_erasable);
    assign w_attempt   = !rst && !halt && !w_err_block && w_room;
    assign w_issue     = w_attempt && !w_erasable;

    // ---------------- return side ----------------
    // The return in a redirect cycle belongs to the old path; the epoch tag
    // keeps any older-path return out after the redirect has taken effect.
    assign w_ret_ok     = r_inflight && (r_infl_epoch == r_epoch) && !redirect;
    assign w_ret_entry  = '{instr: imem_rdata, pc: r_infl_pc};
    assign w_fifo_empty = (w_fifo_cnt == 2'd0);
    assign w_pop        = !redirect && !stall && !w_fifo_empty;
    // Bypass straight into the output register when nothing is queued ahead.
    assign w_push       = w_ret_ok && !(w_fifo_empty && !stall);

    fetch_fifo u_fifo (
        .clock   (clock),
        .rst     (rst),
        .i_clear (redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_ret_entry),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_cnt)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_inflight   <= 1'b0;
            r_infl_epoch <= 1'b0;
            r_infl_pc    <= RESET_PC;
            r_epoch      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_infl_pc    <= w_fa;
                r_infl_epoch <= redirect ? ~r_epoch : r_epoch;
            end
            if (redirect)
                r_epoch <= ~r_epoch;
            if (w_issue)
                r_fetch_pc <= w_fa + 12'd1;
            else if (redirect)
                r_fetch_pc <= redirect_pc;
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clock) begin
        if (rst) begin
            r_instr <= BUBBLE_INSTR;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else if (redirect) begin
            r_instr <= BUBBLE_INSTR;
            r_valid <= 1'b0;
        end else if (!stall) begin
            if (!w_fifo_empty) begin
                r_instr <= w_fifo_head.instr;
                r_pc    <= w_fifo_head.pc;
                r_valid <= 1'b1;
            end else if (w_ret_ok) begin
                r_instr <= imem_rdata;
                r_pc    <= r_infl_pc;
                r_valid <= 1'b1;
            end else begin
                r_instr <= BUBBLE_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: if (w_attempt && w_erasable)  w_state_nxt = ST_ERR;
            ST_ERR: if (redirect && !w_erasable)  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        fetch_err  = (r_state == ST_ERR);
        imem_rd_en = w_issue;
        imem_addr  = ROM_AW'(w_phys);
    end

    assign instr       = r_instr;
    assign pc          = r_pc;
    assign instr_valid = r_valid;

`ifdef FETCH_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clock) begin
        if (rst)
            r_bubble_cnt <= 16'd0;
        else if (!r_valid && !stall && (r_bubble_cnt != 16'hFFFF))
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: doc/fetch.md
# fetch

The instruction fetch stage sits directly upstream of the decode stage and supplies it with `instr`, `pc` and a valid flag.
- Maps the 12-bit AGC program counter and the fixed-bank register `bits_FB` onto a banked physical ROM address.
- Issues one read per cycle to a synchronous ROM with 1-cycle read latency.
- Absorbs decode back-pressure in a 2-entry buffer.
- Replaces the pipeline contents on a branch redirect.

## Interface
Parameters:
- `ROM_AW`, 13, physical ROM word-address width: 8 banks of 1024 words.
- `RESET_PC`, 12'o4000, first fetch address after reset.
- `BUBBLE_INSTR`, 15'o00004, INHINT encoding, which decode treats as a NOOP.

Ports:
- `clock`  in  1  clock for all state.
- `rst`  in  1  reset, synchronous and active-high.
- `stall`  in  1  decode cannot accept a new instruction; the output register holds.
- `halt`  in  1  level input; while high, no new ROM reads are issued.
- `redirect`  in  1  branch taken in a later stage.
- `redirect_pc`  in  12  branch target K address.
- `bits_FB`  in  3  current fixed-bank register.
- `imem_rd_en`  out  1  ROM read strobe.
- `imem_addr`  out  ROM_AW  physical ROM address.
- `imem_rdata`  in  15  ROM data, valid the cycle after `imem_rd_en`.
- `instr`  out  15  instruction to decode.
- `pc`  out  12  K address of `instr`.
- `instr_valid`  out  1  `instr`/`pc` hold a real instruction.
- `fetch_err`  out  1  sticky flag: a fetch from an erasable address was attempted.

## Operation
- Address map for a fetch address `fa`:
  - `fa` in 'o2000–'o3777 → `{bits_FB, fa[9:0]}`.
  - `fa` in 'o4000–'o5777 → `{3'd2, fa[9:0]}`.
  - `fa` in 'o6000–'o7777 → `{3'd3, fa[9:0]}`.
  - `fa` < 'o2000 (erasable) → no read is issued; `fetch_err` is set.
- `bits_FB` is sampled in the cycle the read is issued.
- Issue address: `redirect_pc` when `redirect` is high, otherwise the internal `fetch_pc`.
- Issue condition: `!rst && !halt && !fetch_err && (fifo_count + inflight) <= 1`.
- `fetch_pc` advances by 1, modulo 4096, on each issue. A wrap from 'o7777 to 'o0000 leads to `fetch_err` on the next issue attempt.
- Returned data with its pc enters a 2-entry FIFO. Bypass: when the FIFO is empty and `stall` is low, the data loads the output register directly.
- Output register: when `stall` is low, it loads the FIFO head if there is one, else bypassed data, else the bubble (`BUBBLE_INSTR`, `instr_valid`=0). When `stall` is high it holds.
- Redirect:
  - Discards the FIFO and any in-flight read (the in-flight return is tagged with a 1-bit epoch that toggles on redirect).
  - Loads the bubble into the output register regardless of `stall`.
  - Sets `fetch_pc` to `redirect_pc`+1 when the target is issued.
  - Clears `fetch_err` when the target is ≥ 'o2000.
- FSM:
  - RUN → ERR on an erasable issue attempt.
  - ERR → RUN on a redirect to a valid address.
  - Any state → RUN on `rst`, with `fetch_pc`=`RESET_PC`.

## Timing
- Reset values: `instr`=`BUBBLE_INSTR`, `pc`=`RESET_PC`, `instr_valid`=0, `fetch_err`=0, `imem_rd_en`=0, FIFO empty, inflight=0.
- The first read (address 'o4000 → physical 'o4000) is issued in the first cycle with `rst` low. `instr_valid` rises 2 cycles later.
- Steady state with no stall: one instruction per cycle, 2-cycle issue-to-output latency.
- Redirect in cycle N:
  - Target read issued in N.
  - Output is a bubble in N+1.
  - Target is valid at the output in N+2.
- Redirect and `stall` in the same cycle: redirect wins.
- Redirect and `halt` in the same cycle: `fetch_pc` updates; no read is issued.
- Stall for any duration: at most 2 reads beyond the held instruction are buffered. No instruction is lost or duplicated.
- `rst` asserted mid-operation discards all buffered and in-flight data in that cycle.

## Configuration
- `FETCH_BUBBLE_CNT_EN` defined:
  - Adds output port `bubble_cnt` [15:0], a saturating count of cycles with `instr_valid`=0 and `stall`=0, cleared by `rst`.
  - Saturates at 16'hFFFF.
- Not defined: the port and counter do not exist.

## Structure
- Shared CPU package holds:
  - address-region constants ('o2000, 'o4000, 'o6000);
  - the fixed-fixed bank numbers 2 and 3;
  - `BUBBLE_INSTR`;
  - the fetch FSM state enum.
- Sub-module `fetch_fifo`: 2-entry, 27-bit (instr+pc) FIFO with push, pop, clear and count.
- Address mapping is a function in the package.

## Test plan
- Reset release with the ROM holding a ramp at 'o4000.. → `imem_addr` 'o4000, 'o4001,…; `instr_valid` rises in cycle 2; `pc` 'o4000, 'o4001 back-to-back.
- `stall` high for 5 cycles mid-stream → outputs hold; `imem_rd_en` drops after 2 extra reads; after release, the next pcs follow with no gap or duplicate.
- `redirect` to 'o2345 with `bits_FB`=5 → `imem_addr`=13'o12345 the same cycle; one bubble; then `pc`='o2345, 'o2346.
- `redirect` and `stall` together with the FIFO full → FIFO cleared, bubble output, target appears 2 cycles later.
- `redirect` to 'o1000 → no read; `fetch_err`=1 held; a later redirect to 'o4000 clears it and resumes.
- Under `FETCH_BUBBLE_CNT_EN`: 3 redirects with no stall → `bubble_cnt` increases by 3 plus the 2 reset-startup cycles.
